// File: rtl/pattern_serializer.sv
// pattern_serializer: ready/load word capture shifted out one bit per DIV clocks, MSB first.
// Define SERIALIZER_LSB_FIRST_EN to send din[0] first instead.
module pattern_serializer #(
  parameter int WIDTH = 8,
  parameter int DIV = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  output logic             ready,
  output logic             busy,
  output logic             outbit,
  output logic             bit_valid
);
  localparam int BW = $clog2(WIDTH);
  localparam int DW = DIV > 1 ? $clog2(DIV) : 1;
  localparam logic [BW-1:0] BMAX = BW'(WIDTH - 1);
  localparam logic [DW-1:0] DMAX = DW'(DIV - 1);
  typedef enum logic {IDLE, SHIFT} state_t;
  state_t           state_q;
  logic [WIDTH-1:0] shreg_q;
  logic [BW-1:0]    bit_cnt_q;
  logic [DW-1:0]    div_cnt_q;
  logic             busy_q, outbit_q, bit_valid_q;
  logic             first_bit, next_bit;
  logic [WIDTH-1:0] din_rest, sh_rest;
`ifdef SERIALIZER_LSB_FIRST_EN
  assign first_bit = din[0];
  assign next_bit  = shreg_q[0];
  assign din_rest  = din >> 1;
  assign sh_rest   = shreg_q >> 1;
`else
  assign first_bit = din[WIDTH-1];
  assign next_bit  = shreg_q[WIDTH-1];
  assign din_rest  = din << 1;
  assign sh_rest   = shreg_q << 1;
`endif
  // Ready also in the final hold cycle of the last bit, so words can run back to back.
  assign ready     = state_q == IDLE || (bit_cnt_q == BMAX && div_cnt_q == DMAX);
  assign busy      = busy_q;
  assign outbit    = outbit_q;
  assign bit_valid = bit_valid_q;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      shreg_q     <= '0;
      bit_cnt_q   <= '0;
      div_cnt_q   <= '0;
      busy_q      <= 1'b0;
      outbit_q    <= 1'b0;
      bit_valid_q <= 1'b0;
    end else if (load && ready) begin
      state_q     <= SHIFT;
      shreg_q     <= din_rest;
      bit_cnt_q   <= '0;
      div_cnt_q   <= '0;
      busy_q      <= 1'b1;
      outbit_q    <= first_bit;
      bit_valid_q <= 1'b1;
    end else if (state_q == SHIFT) begin
      if (div_cnt_q != DMAX) begin
        div_cnt_q   <= div_cnt_q + DW'(1);
        bit_valid_q <= 1'b0;
      end else if (bit_cnt_q != BMAX) begin
        div_cnt_q   <= '0;
        bit_cnt_q   <= bit_cnt_q + BW'(1);
        shreg_q     <= sh_rest;
        outbit_q    <= next_bit;
        bit_valid_q <= 1'b1;
      end else begin
        state_q     <= IDLE;
        div_cnt_q   <= '0;
        bit_cnt_q   <= '0;
        busy_q      <= 1'b0;
        outbit_q    <= 1'b0;
        bit_valid_q <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_pattern_serializer.sv
// tb_pattern_serializer: queue-based reference model of the serial stream with a negedge monitor.
module tb_pattern_serializer;
  localparam int W = 8;
  localparam int D = 3;
  logic         clk = 1'b0;
  logic         rst_n, load;
  logic [W-1:0] din;
  logic         ready, busy, outbit, bit_valid;
  int  vecs = 0, errs = 0;
  int  rem = 0;
  int  e;
  bit  run = 1'b0;
  bit  cur = 1'b0;
  bit  exp_bit;
  bit  q[$];
  pattern_serializer #(.WIDTH(W), .DIV(D)) dut (
    .clk(clk), .rst_n(rst_n), .load(load), .din(din),
    .ready(ready), .busy(busy), .outbit(outbit), .bit_valid(bit_valid)
  );
  always #5 clk = ~clk;
  task automatic chk(input string n, input int act, input int want);
    vecs++;
    if (act != want) begin
      errs++;
      $display("FAIL %s got %0d want %0d at %0t", n, act, want, $time);
    end
  endtask
  // Reference: each accepted word occupies W*D cycles; its bits are queued in send order.
  always @(posedge clk) begin
    if (!rst_n) begin
      q.delete();
      rem = 0;
    end else if (load && rem <= 1) begin
      if (run) chk("stale_bits", q.size(), 0);
      q.delete();
      for (int k = 0; k < W; k++)
`ifdef SERIALIZER_LSB_FIRST_EN
        q.push_back(din[k]);
`else
        q.push_back(din[W-1-k]);
`endif
      rem = W * D;
    end else if (rem > 0) rem--;
  end
  always @(negedge clk) begin
    if (run) begin
      e = W * D - rem;
      chk("busy", int'(busy), int'(rem > 0));
      chk("ready", int'(ready), int'(rem <= 1));
      chk("strobe", int'(bit_valid), int'(rem > 0 && e % D == 0));
      if (rem == 0) chk("idle_out", int'(outbit), 0);
      else if (e % D == 0) begin
        if (q.size() == 0) chk("bit_underrun", 0, 1);
        else begin
          exp_bit = q.pop_front();
          chk("bit", int'(outbit), int'(exp_bit));
          cur = exp_bit;
        end
      end else chk("hold", int'(outbit), int'(cur));
    end
  end
  task automatic send(input logic [W-1:0] d);
    load = 1'b1;
    din  = d;
    @(negedge clk);
    load = 1'b0;
  endtask
  task automatic wait_rem(input int lim);
    for (int i = 0; i < 2000 && rem > lim; i++) @(negedge clk);
    if (rem > lim) chk("wait_timeout", rem, lim);
  endtask
  initial begin
    rst_n = 1'b0;
    load  = 1'b1;
    din   = 8'hFF;
    @(posedge clk);
    run = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    load  = 1'b0;
    send(8'h90);
    wait_rem(0);
    send(8'hA5);
    wait_rem(1);
    send(8'h3C);
    wait_rem(0);
    send(8'h00);
    repeat (4) @(negedge clk);
    send(8'hFF);
    wait_rem(0);
    send(8'hF0);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    send(8'h5A);
    wait_rem(0);
    for (int i = 0; i < 3000; i++) begin
      rst_n = $urandom_range(0, 99) != 0;
      load  = $urandom_range(0, 2) == 0;
      din   = W'($urandom);
      @(negedge clk);
    end
    rst_n = 1'b1;
    load  = 1'b0;
    wait_rem(0);
    @(negedge clk);
    chk("leftover", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
